aeolus_alu_datapath: RTL and testbench
======================================

AEOLUS_ALU_DATAPATH -- requirements
Module: aeolus_alu_datapath

Interface
REQ-001 Parameter INPUT_DATA_WIDTH, default 4, width of operand registers A and B.
REQ-002 Parameter OUTPUT_DATA_WIDTH, default 8, width of ALU, shifter and accumulator paths.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 ADD, SUB, AND, OR, XOR, INV, CLR  input  1 each  decoded opcode strobes.
REQ-006 SNZA, SNZS  input  1 each  conditional-add strobes, gated by SF.
REQ-007 SF  input  1  shift flag from the shift register.
REQ-008 A, B  input  INPUT_DATA_WIDTH  register-file operands.
REQ-009 shiftIn  input  OUTPUT_DATA_WIDTH  shift-register contents.
REQ-010 aluOut  output  OUTPUT_DATA_WIDTH  combinational ALU result.
REQ-011 overflow  output  1  combinational carry/borrow of the current operation.
REQ-012 addEff  output  1  effective ADD control (ADD_MUX result).
REQ-013 accEnable  output  1  accumulator load enable.
REQ-014 accOut  output  OUTPUT_DATA_WIDTH  registered accumulator.
REQ-015 ofFlag  output  1  registered overflow flag.

Function
REQ-016 addEff SHALL = ADD | (SNZA & SF) | (SNZS & SF).
REQ-017 Operand select SHALL be: SNZS&SF -> in1=accOut, in2=shiftIn; else SNZA&SF -> in1=accOut, in2=zero-extended A; otherwise in1=zero-extended A, in2=zero-extended B.
REQ-018 Op priority SHALL be CLR > addEff > SUB > AND > OR > XOR > INV; exactly one op takes effect.
REQ-019 CLR: aluOut=0, overflow=0.
REQ-020 addEff: aluOut=(in1+in2) mod 2^OUTPUT_DATA_WIDTH, overflow=carry out of MSB.
REQ-021 SUB: aluOut=(in1-in2) mod 2^OUTPUT_DATA_WIDTH, overflow=1 when in1<in2 unsigned (borrow).
REQ-022 AND/OR/XOR: bitwise on in1,in2; overflow=0.
REQ-023 INV: aluOut=~in1 (full OUTPUT_DATA_WIDTH bits, zero-extension bits included); overflow=0.
REQ-024 No op asserted: aluOut=0, overflow=0.
REQ-025 accEnable SHALL = CLR|addEff|SUB|AND|OR|XOR|INV; SNZA/SNZS with SF=0 SHALL NOT enable.
REQ-026 On clk edge with accEnable=1: accOut<=aluOut, ofFlag<=overflow; else both hold.
REQ-027 CLR SHALL synchronously clear accOut and ofFlag to 0 on the next edge.
REQ-028 aluOut/overflow/addEff/accEnable SHALL be purely combinational (zero latency); accOut/ofFlag have one-cycle latency.
REQ-029 Wrap-around SHALL be silent modulo arithmetic; flag captured only via ofFlag.

Reset
REQ-030 reset=0 at a rising edge SHALL force accOut=0 and ofFlag=0, overriding all op strobes.
REQ-031 Combinational outputs SHALL remain functional during reset (driven from current inputs and accOut).
REQ-032 Releasing reset SHALL resume normal operation on the next edge with no extra cycle.

Verification
REQ-033 A=4'hF, B=4'h1, ADD -> aluOut=8'h10, overflow=0; after edge accOut=8'h10.
REQ-034 A=4'h3, B=4'h5, SUB -> aluOut=8'hFE, overflow=1; after edge ofFlag=1.
REQ-035 accOut=8'h0C, SF=1, SNZA, A=4'h3 -> aluOut=8'h0F, accEnable=1; same with SF=0 -> accEnable=0, accOut holds 8'h0C.
REQ-036 accOut=8'hF0, SF=1, SNZS, shiftIn=8'h20 -> aluOut=8'h10, overflow=1; after edge accOut=8'h10, ofFlag=1.
REQ-037 A=4'hA, INV -> aluOut=8'hF5; then CLR with ADD also asserted -> after edge accOut=0, ofFlag=0.
REQ-038 accOut=8'h55, reset=0 with ADD asserted -> after edge accOut=0, ofFlag=0.

Source files
------------

// File: rtl/aeolus_alu_datapath.sv
// aeolus_alu_datapath: operand select, priority-encoded ALU and a registered
// accumulator with overflow flag. The ALU path is combinational; only the
// accumulator and its flag are clocked.
module aeolus_alu_datapath #(
    parameter int unsigned INPUT_DATA_WIDTH  = 4,
    parameter int unsigned OUTPUT_DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ADD,
    input  logic                         SUB,
    input  logic                         AND,
    input  logic                         OR,
    input  logic                         XOR,
    input  logic                         INV,
    input  logic                         CLR,
    input  logic                         SNZA,
    input  logic                         SNZS,
    input  logic                         SF,
    input  logic [INPUT_DATA_WIDTH-1:0]  A,
    input  logic [INPUT_DATA_WIDTH-1:0]  B,
    input  logic [OUTPUT_DATA_WIDTH-1:0] shiftIn,
    output logic [OUTPUT_DATA_WIDTH-1:0] aluOut,
    output logic                         overflow,
    output logic                         addEff,
    output logic                         accEnable,
    output logic [OUTPUT_DATA_WIDTH-1:0] accOut,
    output logic                         ofFlag
);

    logic [OUTPUT_DATA_WIDTH-1:0] a_ext;
    logic [OUTPUT_DATA_WIDTH-1:0] b_ext;
    logic [OUTPUT_DATA_WIDTH-1:0] in1;
    logic [OUTPUT_DATA_WIDTH-1:0] in2;
    logic [OUTPUT_DATA_WIDTH:0]   sum_ext;
    logic [OUTPUT_DATA_WIDTH:0]   diff_ext;
    logic                         snzs_eff;
    logic                         snza_eff;

    // Conditional-add strobes only count when the shift flag is set
    always_comb begin
        snzs_eff  = SNZS & SF;
        snza_eff  = SNZA & SF;
        addEff    = ADD | snza_eff | snzs_eff;
        accEnable = CLR | addEff | SUB | AND | OR | XOR | INV;
    end

    // Zero-extend register-file operands and pick the ALU inputs
    always_comb begin
        a_ext = '0;
        b_ext = '0;
        a_ext[INPUT_DATA_WIDTH-1:0] = A;
        b_ext[INPUT_DATA_WIDTH-1:0] = B;
        if (snzs_eff) begin
            in1 = accOut;
            in2 = shiftIn;
        end else if (snza_eff) begin
            in1 = accOut;
            in2 = a_ext;
        end else begin
            in1 = a_ext;
            in2 = b_ext;
        end
    end

    // Priority-ordered ALU; the extra MSB of the wide sum/difference is the carry/borrow
    always_comb begin
        sum_ext  = {1'b0, in1} + {1'b0, in2};
        diff_ext = {1'b0, in1} - {1'b0, in2};
        aluOut   = '0;
        overflow = 1'b0;
        if (CLR) begin
            aluOut   = '0;
            overflow = 1'b0;
        end else if (addEff) begin
            aluOut   = sum_ext[OUTPUT_DATA_WIDTH-1:0];
            overflow = sum_ext[OUTPUT_DATA_WIDTH];
        end else if (SUB) begin
            aluOut   = diff_ext[OUTPUT_DATA_WIDTH-1:0];
            overflow = diff_ext[OUTPUT_DATA_WIDTH];
        end else if (AND) begin
            aluOut = in1 & in2;
        end else if (OR) begin
            aluOut = in1 | in2;
        end else if (XOR) begin
            aluOut = in1 ^ in2;
        end else if (INV) begin
            aluOut = ~in1;
        end
    end

    // Accumulator and overflow flag; CLR lands here as an ALU result of zero
    always_ff @(posedge clk) begin
        if (!reset) begin
            accOut <= '0;
            ofFlag <= 1'b0;
        end else if (accEnable) begin
            accOut <= aluOut;
            ofFlag <= overflow;
        end
    end

endmodule

// File: tb/tb_aeolus_alu_datapath.sv
// Directed testbench for aeolus_alu_datapath with hand-computed expectations.
module tb_aeolus_alu_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic       ADD, SUB, AND, OR, XOR, INV, CLR, SNZA, SNZS, SF;
    logic [3:0] A, B;
    logic [7:0] shiftIn;
    logic [7:0] aluOut;
    logic       overflow;
    logic       addEff;
    logic       accEnable;
    logic [7:0] accOut;
    logic       ofFlag;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    aeolus_alu_datapath #(
        .INPUT_DATA_WIDTH (4),
        .OUTPUT_DATA_WIDTH(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ADD      (ADD),
        .SUB      (SUB),
        .AND      (AND),
        .OR       (OR),
        .XOR      (XOR),
        .INV      (INV),
        .CLR      (CLR),
        .SNZA     (SNZA),
        .SNZS     (SNZS),
        .SF       (SF),
        .A        (A),
        .B        (B),
        .shiftIn  (shiftIn),
        .aluOut   (aluOut),
        .overflow (overflow),
        .addEff   (addEff),
        .accEnable(accEnable),
        .accOut   (accOut),
        .ofFlag   (ofFlag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        {ADD, SUB, AND, OR, XOR, INV, CLR, SNZA, SNZS, SF} = '0;
        A = '0;
        B = '0;
        shiftIn = '0;
    endtask

    // Advance through one rising edge, then settle a little past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        tick();
        check("rst_acc", accOut, 8'h00);
        check("rst_of", ofFlag, 1'b0);
        reset = 1'b1;

        // Idle: nothing enabled, accumulator holds
        #1;
        check("idle_alu", aluOut, 8'h00);
        check("idle_en", accEnable, 1'b0);

        // ADD F+1
        A = 4'hF; B = 4'h1; ADD = 1'b1; #1;
        check("add_alu", aluOut, 8'h10);
        check("add_ov", overflow, 1'b0);
        check("add_eff", addEff, 1'b1);
        check("add_en", accEnable, 1'b1);
        tick();
        check("add_acc", accOut, 8'h10);
        check("add_of", ofFlag, 1'b0);

        // SUB 3-5 borrows
        idle(); A = 4'h3; B = 4'h5; SUB = 1'b1; #1;
        check("sub_alu", aluOut, 8'hFE);
        check("sub_ov", overflow, 1'b1);
        check("sub_eff", addEff, 1'b0);
        tick();
        check("sub_acc", accOut, 8'hFE);
        check("sub_of", ofFlag, 1'b1);

        // SUB equal and SUB no-borrow
        idle(); A = 4'h7; B = 4'h7; SUB = 1'b1; #1;
        check("subeq_alu", aluOut, 8'h00);
        check("subeq_ov", overflow, 1'b0);
        A = 4'h5; B = 4'h3; #1;
        check("sub2_alu", aluOut, 8'h02);
        check("sub2_ov", overflow, 1'b0);

        // ADD beats SUB
        ADD = 1'b1; A = 4'h3; B = 4'h5; #1;
        check("prio_add_alu", aluOut, 8'h08);

        // Logic ops on C, A
        idle(); A = 4'hC; B = 4'hA;
        AND = 1'b1; #1; check("and_alu", aluOut, 8'h08);
        AND = 1'b0; OR = 1'b1; #1; check("or_alu", aluOut, 8'h0E);
        OR = 1'b0; XOR = 1'b1; #1; check("xor_alu", aluOut, 8'h06);
        check("xor_ov", overflow, 1'b0);
        // AND beats XOR
        AND = 1'b1; #1; check("prio_and_alu", aluOut, 8'h08);

        // Load 0C via OR with B=0
        idle(); A = 4'hC; OR = 1'b1; tick();
        check("ld0c_acc", accOut, 8'h0C);
        check("ld0c_of", ofFlag, 1'b0);

        // SNZA with SF=1: acc + A
        idle(); A = 4'h3; SNZA = 1'b1; SF = 1'b1; #1;
        check("snza_alu", aluOut, 8'h0F);
        check("snza_en", accEnable, 1'b1);
        check("snza_eff", addEff, 1'b1);
        // same with SF=0: disabled, accumulator holds
        SF = 1'b0; #1;
        check("snza_nsf_en", accEnable, 1'b0);
        check("snza_nsf_eff", addEff, 1'b0);
        check("snza_nsf_alu", aluOut, 8'h00);
        tick();
        check("snza_hold", accOut, 8'h0C);
        SNZA = 1'b0; SNZS = 1'b1; #1;
        check("snzs_nsf_en", accEnable, 1'b0);

        // Load F0 via INV of 0F
        idle(); A = 4'hF; INV = 1'b1; #1;
        check("inv_alu", aluOut, 8'hF0);
        tick();
        check("ldf0_acc", accOut, 8'hF0);

        // SNZS with SF=1: F0+20 wraps with carry
        idle(); shiftIn = 8'h20; SNZS = 1'b1; SF = 1'b1; #1;
        check("snzs_alu", aluOut, 8'h10);
        check("snzs_ov", overflow, 1'b1);
        // SNZS operand select beats SNZA
        SNZA = 1'b1; A = 4'h1; #1;
        check("snzs_prio_alu", aluOut, 8'h10);
        SNZA = 1'b0;
        tick();
        check("snzs_acc", accOut, 8'h10);
        check("snzs_of", ofFlag, 1'b1);

        // INV of A: zero-extension bits invert too
        idle(); A = 4'hA; INV = 1'b1; #1;
        check("inv2_alu", aluOut, 8'hF5);
        check("inv2_ov", overflow, 1'b0);

        // Set ofFlag, then CLR with ADD clears both
        idle(); A = 4'h3; B = 4'h5; SUB = 1'b1; tick();
        check("pre_clr_of", ofFlag, 1'b1);
        idle(); A = 4'hF; B = 4'hF; CLR = 1'b1; ADD = 1'b1; #1;
        check("clr_alu", aluOut, 8'h00);
        check("clr_ov", overflow, 1'b0);
        check("clr_en", accEnable, 1'b1);
        tick();
        check("clr_acc", accOut, 8'h00);
        check("clr_of", ofFlag, 1'b0);

        // Load 55 via SNZS on a zero accumulator
        idle(); shiftIn = 8'h55; SNZS = 1'b1; SF = 1'b1; tick();
        check("ld55_acc", accOut, 8'h55);

        // Reset with ADD asserted; combinational path still live
        idle(); A = 4'hF; B = 4'h1; ADD = 1'b1; reset = 1'b0; #1;
        check("rst_comb_alu", aluOut, 8'h10);
        check("rst_comb_en", accEnable, 1'b1);
        tick();
        check("rst2_acc", accOut, 8'h00);
        check("rst2_of", ofFlag, 1'b0);
        // Release: next edge loads immediately
        reset = 1'b1;
        tick();
        check("rel_acc", accOut, 8'h10);

        // No op: holds
        idle(); tick();
        check("noop_hold", accOut, 8'h10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
